// File: rtl/led_pkg.sv
// led_pkg: mode encodings and timing constants shared by the LED driver.
package led_pkg;
    localparam logic [2:0] LED_OFF   = 3'd0;
    localparam logic [2:0] LED_ON    = 3'd1;
    localparam logic [2:0] LED_SLOW  = 3'd2;
    localparam logic [2:0] LED_FAST  = 3'd3;
    localparam logic [2:0] LED_VARY  = 3'd4;
    localparam logic [2:0] LED_PULSE = 3'd5;
    localparam int TICK_HZ  = 10;
    localparam int VARY_LEN = 20;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel holding its mode register, tick phase, pulse stretch and output register.
module led_channel
    import led_pkg::*;
#(
    parameter int PULSE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode_i,
    input  logic       trigger_i,
    input  logic       tick_i,
    input  logic       gate_i,
    output logic       led_o
);
    logic [2:0] mode_q;
    logic [4:0] cnt_q, cnt_d, cnt_eff;
    logic [3:0] str_q, str_d;
    logic       led_q, led_d, changed, raw;

    // A mode change decodes against a zero phase so every flash mode starts lit.
    always_comb begin
        changed = mode_i != mode_q;
        cnt_eff = changed ? 5'd0 : cnt_q;
        cnt_d   = changed ? 5'd0 : !tick_i ? cnt_q : cnt_q == 5'(VARY_LEN - 1) ? 5'd0 : cnt_q + 5'd1;
        str_d   = mode_i != LED_PULSE ? 4'd0 : trigger_i ? 4'(PULSE_TICKS) :
                  (tick_i && str_q != 4'd0) ? str_q - 4'd1 : str_q;
        raw     = mode_i == LED_ON    ? 1'b1 :
                  mode_i == LED_SLOW  ? (cnt_eff < 5'd5 || (cnt_eff >= 5'd10 && cnt_eff < 5'd15)) :
                  mode_i == LED_FAST  ? ~cnt_eff[0] :
                  mode_i == LED_VARY  ? (cnt_eff < 5'd10 ? ~cnt_eff[0] : cnt_eff < 5'd15) :
                  mode_i == LED_PULSE ? (trigger_i | (str_q != 4'd0)) : 1'b0;
        led_d   = raw & gate_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= LED_OFF;
            cnt_q  <= '0;
            str_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_i;
            cnt_q  <= cnt_d;
            str_q  <= str_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/led_control_multi.sv
// led_control_multi: multi-channel LED driver with shared 10 Hz timebase and global brightness PWM.
module led_control_multi
    import led_pkg::*;
#(
    parameter int CLOCK_SPEED = 25000000,
    parameter int CHANNELS    = 4,
    parameter int PWM_BITS    = 8,
    parameter int PULSE_TICKS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [3*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   trigger,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [CHANNELS-1:0]   led
);
    localparam int DIV   = CLOCK_SPEED / TICK_HZ;
    localparam int DIV_W = DIV > 1 ? $clog2(DIV) : 1;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick, gate;

    // Full-scale brightness must light continuously, which a plain compare cannot reach.
    always_comb begin
        tick  = div_q == DIV_W'(DIV - 1);
        div_d = tick ? '0 : div_q + DIV_W'(1);
        pwm_d = pwm_q + PWM_BITS'(1);
        gate  = (&brightness) | (pwm_q < brightness);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            pwm_q <= '0;
        end else begin
            div_q <= div_d;
            pwm_q <= pwm_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_channel #(.PULSE_TICKS(PULSE_TICKS)) u_ch (
            .clk       (clock),
            .rst_n     (reset_n),
            .mode_i    (mode[3*g +: 3]),
            .trigger_i (trigger[g]),
            .tick_i    (tick),
            .gate_i    (gate),
            .led_o     (led[g])
        );
    end
endmodule

// File: tb/tb_led_control_multi.sv
// tb_led_control_multi: directed checks of reset, flash, vary, pulse, PWM and mode-change timing.
module tb_led_control_multi;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] mode = '0;
    logic [3:0]  trigger = '0;
    logic [3:0]  brightness = 4'hf;
    logic [3:0]  led;
    int          n_checks = 0;
    int          n_pass = 0;

    led_control_multi #(
        .CLOCK_SPEED (100),
        .CHANNELS    (4),
        .PWM_BITS    (4),
        .PULSE_TICKS (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mode       (mode),
        .trigger    (trigger),
        .brightness (brightness),
        .led        (led)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves reset released just after an edge, so the next step() lands on edge 1.
    task automatic restart(input logic [11:0] m, input logic [3:0] b);
        reset_n = 1'b0;
        mode = m;
        trigger = '0;
        brightness = b;
        step();
        step();
        check("rst_hold", led, 4'b0000);
        reset_n = 1'b1;
    endtask

    // Expected level at edge k after release; ticks land on edges 10, 20, ...
    function automatic logic fast_at(input int k);
        return ((k - 1) / 10) % 2 == 0;
    endfunction

    function automatic logic slow_at(input int k);
        return ((k - 1) / 50) % 2 == 0;
    endfunction

    function automatic logic vary_at(input int k);
        int c;
        c = ((k - 1) / 10) % 20;
        return c < 10 ? (c % 2 == 0) : (c < 15);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        restart({4{3'd1}}, 4'hf);
        step();
        check("rst_release", led, 4'b1111);
        repeat (5) step();
        check("on_steady", led, 4'b1111);
        reset_n = 1'b0;
        #1;
        check("rst_async", led, 4'b0000);

        restart({3'd0, 3'd4, 3'd3, 3'd2}, 4'hf);
        for (int k = 1; k <= 210; k++) begin
            step();
            check("flash_vary", led, {1'b0, vary_at(k), fast_at(k), slow_at(k)});
        end

        restart({3'd5, 9'd0}, 4'hf);
        for (int k = 1; k <= 35; k++) begin
            trigger = {((k >= 4 && k <= 6) || k == 13), 3'b001};
            step();
            check("pulse", led, {(k >= 4 && k <= 30), 3'b000});
        end
        trigger = '0;

        restart({4{3'd1}}, 4'd4);
        for (int k = 1; k <= 32; k++) begin
            step();
            check("pwm4", led, ((k - 1) % 16 < 4) ? 4'hf : 4'h0);
        end
        brightness = 4'd0;
        step();
        for (int k = 0; k < 20; k++) begin
            step();
            check("pwm0", led, 4'h0);
        end
        brightness = 4'hf;
        step();
        for (int k = 0; k < 20; k++) begin
            step();
            check("pwm15", led, 4'hf);
        end
        reset_n = 1'b0;
        #1;
        check("rst_async2", led, 4'b0000);

        restart({6'd0, 3'd3, 3'd0}, 4'hf);
        for (int k = 1; k <= 85; k++) begin
            mode = k >= 30 ? {6'd0, 3'd2, 3'd0} : {6'd0, 3'd3, 3'd0};
            step();
            check("mode_change", led, {2'b00, (k < 30 ? fast_at(k) : (k <= 80)), 1'b0});
        end
        mode = {3'd1, 3'd1, 3'd7, 3'd6};
        step();
        check("reserved", led, 4'b1100);
        step();
        check("reserved2", led, 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
